m_ram8: RTL and testbench

- 8-word x 16-bit read/write memory, built as the load-routing consumer of the 1-to-2 demultiplexer stage.
- A 3-level dmux tree steers `i_load` to exactly one of eight 16-bit registers.
- An 8-way mux returns the addressed word.
- First memory block in the hierarchy; RAM64 and larger banks stack it.

---
 rtl/m_ram8.sv | 62 ++++++
 tb/tb_m_ram8.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/m_ram8.sv
// 8-word x 16-bit register memory: a three-level dmux tree routes the write enable
// to one word, and an 8-way mux returns the addressed word combinationally.
module m_ram8 #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_in,
  input  logic              i_load,
  input  logic [2:0]        i_address,
  output logic [DATA_W-1:0] o_out
);

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [1:0]       load_l1;
  logic [3:0]       load_l2;
  logic [DEPTH-1:0] load_l3;
  logic [DATA_W-1:0] word_reg [DEPTH];

  // First level splits on the address MSB; each later level halves the range again.
  assign load_l1[1] = i_load &  i_address[2];
  assign load_l1[0] = i_load & ~i_address[2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dmux_l2
      if ((gi % 2) == 1) begin : g_hi
        assign load_l2[gi] = load_l1[gi / 2] &  i_address[1];
      end else begin : g_lo
        assign load_l2[gi] = load_l1[gi / 2] & ~i_address[1];
      end
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_dmux_l3
      if ((gi % 2) == 1) begin : g_hi
        assign load_l3[gi] = load_l2[gi / 2] &  i_address[0];
      end else begin : g_lo
        assign load_l3[gi] = load_l2[gi / 2] & ~i_address[0];
      end
    end
  endgenerate

  // Reset clears every word immediately and also blocks writes while held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load_l3[i]) begin
          word_reg[i] <= i_in;
        end
      end
    end
  end

  assign o_out = word_reg[i_address];

endmodule

// File: tb/tb_m_ram8.sv
// Directed self-checking bench for m_ram8: reset, readback, load gating,
// read-before-write, asynchronous reset mid-sequence and decode isolation.
module tb_m_ram8;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        load;
  logic [2:0]  addr;
  logic [15:0] dout;

  int checks;
  int failures;
  logic [15:0] model [8];

  m_ram8 #(.DATA_W(16)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_in      (din),
    .i_load    (load),
    .i_address (addr),
    .o_out     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%04h exp=%04h", tag, got, exp);
    end else begin
      $display("ok   %s got=%04h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    addr = a;
    din  = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    model[a] = d;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      #1;
      check($sformatf("%s_a%0d", tag, i), dout, model[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nz;
    checks = 0;
    failures = 0;
    clear_model();
    rst = 1'b1; load = 1'b0; din = '0; addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset with random prior contents, load held high across an edge while in reset.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'($urandom_range(1, 16'hFFFF)));
    #2;
    din = 16'hDEAD; load = 1'b1; addr = 3'd1;
    rst = 1'b1;
    #1;
    check("rst_immediate", dout, 16'h0000);
    clear_model();
    tick();
    sweep("rst_held");
    rst = 1'b0; load = 1'b0;
    tick();
    sweep("rst_after");

    // Write/readback all words.
    for (int n = 0; n < 7; n++) wr(3'(n), 16'(16'h1111 * (n + 1)));
    wr(3'd7, 16'hFFFF);
    sweep("wr_all");

    // Load gating.
    wr(3'd3, 16'hABCD);
    addr = 3'd3; din = 16'h0000; load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("gate_e%0d", k), dout, 16'hABCD);
    end

    // Read-before-write.
    wr(3'd5, 16'h1234);
    addr = 3'd5; din = 16'h5678; load = 1'b1;
    #1;
    check("rbw_before", dout, 16'h1234);
    tick();
    load = 1'b0;
    check("rbw_after", dout, 16'h5678);
    addr = 3'd4; #1;
    check("rbw_a4", dout, 16'h5555);
    addr = 3'd6; #1;
    check("rbw_a6", dout, 16'h7777);
    model[5] = 16'h5678;

    // Asynchronous reset right after a write, load held high.
    wr(3'd2, 16'hBEEF);
    check("beef_written", dout, 16'hBEEF);
    din = 16'h4321; load = 1'b1; addr = 3'd2;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_now", dout, 16'h0000);
    tick();
    check("mid_rst_edge", dout, 16'h0000);
    load = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_after", dout, 16'h0000);
    clear_model();
    tick();
    sweep("mid_rst_all");

    // Decode isolation over all-zero memory.
    for (int n = 0; n < 8; n++) begin
      wr(3'(n), 16'h8001);
      nz = 0;
      for (int i = 0; i < 8; i++) begin
        addr = 3'(i);
        #1;
        if (dout != 16'h0000) nz++;
        check($sformatf("iso_w%0d_a%0d", n, i), dout, (i <= n) ? 16'h8001 : 16'h0000);
      end
      check($sformatf("iso_count_w%0d", n), 16'(nz), 16'(n + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
